// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-port memory between instruction fetch and the data stage.
// Data access has priority; a starvation counter eventually forces a fetch grant.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IfReq,
  input  logic [31:0] IfAddr,
  output logic        IfGnt,
  output logic        IfValid,
  output logic [31:0] IfRdata,
  input  logic        DmReq,
  input  logic        DmWe,
  input  logic [31:0] DmAddr,
  input  logic [31:0] DmWdata,
  input  logic [1:0]  DmSize,
  output logic        DmGnt,
  output logic        DmValid,
  output logic [31:0] DmRdata,
  output logic        MemEn,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  output logic [1:0]  MemSize,
  input  logic [31:0] MemRdata,
  output logic        StallIF,
  output logic        StallMEM
);

  localparam logic [1:0] NONE    = 2'd0;
  localparam logic [1:0] IF_PEND = 2'd1;
  localparam logic [1:0] DM_PEND = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] if_rdata_q, dm_rdata_q;
  logic        force_if;

  // Every output is gated by Reset so the reset cycle presents no grant and no response.
  always_comb begin
    force_if = (starve_q == 4'(STARVE_MAX));
    IfGnt    = Reset & IfReq & (~DmReq | force_if);
    DmGnt    = Reset & DmReq & ~IfGnt;
    StallIF  = Reset & IfReq & ~IfGnt;
    StallMEM = Reset & DmReq & ~DmGnt;

    MemEn    = IfGnt | DmGnt;
    MemWe    = DmGnt & DmWe;
    MemAddr  = '0;
    MemWdata = '0;
    MemSize  = '0;
    if (DmGnt) begin
      MemAddr  = DmAddr;
      MemWdata = DmWdata;
      MemSize  = DmSize;
    end else if (IfGnt) begin
      MemAddr  = IfAddr;
      MemSize  = 2'b10;
    end

    IfValid = Reset & (state_q == IF_PEND);
    DmValid = Reset & (state_q == DM_PEND);
    IfRdata = IfValid ? MemRdata : if_rdata_q;
    DmRdata = (DmValid && !dm_we_q) ? MemRdata : dm_rdata_q;
  end

  always_comb begin
    state_d = NONE;
    if (IfGnt)      state_d = IF_PEND;
    else if (DmGnt) state_d = DM_PEND;
    dm_we_d  = DmGnt & DmWe;
    starve_d = (IfReq && !IfGnt) ? starve_q + 4'd1 : '0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= NONE;
      starve_q   <= '0;
      dm_we_q    <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      dm_we_q    <= dm_we_d;
      if_rdata_q <= IfRdata;
      dm_rdata_q <= DmRdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected cycle outputs and
// responses into queues, an independent monitor pops and compares them.
module tb_mem_port_arbiter;
  localparam int SM = 4;

  logic        Clk = 0;
  logic        Reset, IfReq, DmReq, DmWe;
  logic [31:0] IfAddr, DmAddr, DmWdata, MemRdata;
  logic [1:0]  DmSize;
  logic        IfGnt, IfValid, DmGnt, DmValid, MemEn, MemWe, StallIF, StallMEM;
  logic [31:0] IfRdata, DmRdata, MemAddr, MemWdata;
  logic [1:0]  MemSize;

  mem_port_arbiter #(.STARVE_MAX(SM)) dut (
    .Clk(Clk), .Reset(Reset), .IfReq(IfReq), .IfAddr(IfAddr), .IfGnt(IfGnt),
    .IfValid(IfValid), .IfRdata(IfRdata), .DmReq(DmReq), .DmWe(DmWe),
    .DmAddr(DmAddr), .DmWdata(DmWdata), .DmSize(DmSize), .DmGnt(DmGnt),
    .DmValid(DmValid), .DmRdata(DmRdata), .MemEn(MemEn), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemWdata(MemWdata), .MemSize(MemSize),
    .MemRdata(MemRdata), .StallIF(StallIF), .StallMEM(StallMEM)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          cyc;
    bit          rst;
    bit          ifg, dmg, we;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    bit          stif, stdm;
  } cyc_t;

  typedef struct {
    int          due;
    bit          is_dm;
    bit          we;
    logic [31:0] data;
  } resp_t;

  cyc_t  cycq[$];
  resp_t respq[$];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int deny = 0;
  logic [31:0] pend_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Reference: fetch wins when data is idle or fetch has been refused STARVE_MAX times in a row.
  task automatic drive(input bit rst, input bit ifr, input logic [31:0] ifa,
                       input bit dmr, input bit dmwe, input logic [31:0] dma,
                       input logic [31:0] dmwd, input logic [1:0] dms,
                       input logic [31:0] nrd, output bit ifg, output bit dmg);
    cyc_t c;
    @(posedge Clk);
    #1;
    Reset = rst; IfReq = ifr; IfAddr = ifa; DmReq = dmr; DmWe = dmwe;
    DmAddr = dma; DmWdata = dmwd; DmSize = dms;
    MemRdata = pend_rd;
    pend_rd = nrd;
    ncyc++;
    if (!rst) begin
      while (respq.size() > 0 && respq[respq.size()-1].due == ncyc) void'(respq.pop_back());
      deny = 0; ifg = 0; dmg = 0;
    end else begin
      ifg  = ifr && (!dmr || deny == SM);
      dmg  = dmr && !ifg;
      deny = (ifr && !ifg) ? deny + 1 : 0;
    end
    c.cyc = ncyc; c.rst = !rst; c.ifg = ifg; c.dmg = dmg; c.we = dmg && dmwe;
    c.addr = dmg ? dma : ifa; c.wdata = dmwd; c.size = dmg ? dms : 2'b10;
    c.stif = rst && ifr && !ifg; c.stdm = rst && dmr && !dmg;
    cycq.push_back(c);
    if (ifg) respq.push_back('{ncyc + 1, 1'b0, 1'b0, pend_rd});
    if (dmg) respq.push_back('{ncyc + 1, 1'b1, dmwe, pend_rd});
  endtask

  // Monitor: compares the DUT at the falling edge against the queued expectations.
  initial begin : monitor
    cyc_t r;
    resp_t p;
    bit ev_if, ev_dm;
    logic [31:0] last_if = '0, last_dm = '0, e_if, e_dm;
    forever begin
      @(negedge Clk);
      if (cycq.size() > 0) begin
        r = cycq.pop_front();
        chk("IfGnt", 32'(IfGnt), 32'(r.ifg));
        chk("DmGnt", 32'(DmGnt), 32'(r.dmg));
        chk("MemEn", 32'(MemEn), 32'(r.ifg | r.dmg));
        chk("MemWe", 32'(MemWe), 32'(r.we));
        chk("StallIF", 32'(StallIF), 32'(r.stif));
        chk("StallMEM", 32'(StallMEM), 32'(r.stdm));
        if (r.ifg || r.dmg) begin
          chk("MemAddr", MemAddr, r.addr);
          chk("MemSize", 32'(MemSize), 32'(r.size));
        end
        if (r.dmg) chk("MemWdata", MemWdata, r.wdata);
        ev_if = 0; ev_dm = 0; e_if = last_if; e_dm = last_dm;
        if (respq.size() > 0 && respq[0].due == r.cyc) begin
          p = respq.pop_front();
          if (p.is_dm) begin
            ev_dm = 1;
            if (!p.we) e_dm = p.data;
          end else begin
            ev_if = 1;
            e_if = p.data;
          end
        end
        chk("IfValid", 32'(IfValid), 32'(ev_if));
        chk("DmValid", 32'(DmValid), 32'(ev_dm));
        if (!r.rst) begin
          chk("IfRdata", IfRdata, e_if);
          chk("DmRdata", DmRdata, e_dm);
          last_if = e_if; last_dm = e_dm;
        end else begin
          last_if = '0; last_dm = '0;
        end
      end
    end
  end

  initial begin : stim
    bit g1, g2;
    bit ir, dr, dw;
    logic [31:0] ia, da, dwd;
    logic [1:0] ds;
    Reset = 0; IfReq = 0; DmReq = 0; DmWe = 0; IfAddr = '0; DmAddr = '0;
    DmWdata = '0; DmSize = '0; MemRdata = '0;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, g1, g2);
    drive(0, 1, 32'h80, 1, 0, 32'h10, 0, 2'b10, 0, g1, g2);
    // Lone fetch, then fetch contending with a store.
    drive(1, 1, 32'h40, 0, 0, 0, 0, 0, 32'h2002000A, g1, g2);
    drive(1, 0, 0, 0, 0, 0, 0, 0, $urandom, g1, g2);
    drive(1, 1, 32'h44, 1, 1, 32'h100, 32'h5, 2'b10, $urandom, g1, g2);
    drive(1, 1, 32'h44, 0, 0, 0, 0, 0, $urandom, g1, g2);
    drive(1, 0, 0, 0, 0, 0, 0, 0, $urandom, g1, g2);
    // Both requesters saturated: starvation forcing.
    for (int i = 0; i < 16; i++)
      drive(1, 1, 32'h200 + 32'(i * 4), 1, 1'($urandom), $urandom, $urandom,
            2'($urandom_range(0, 2)), $urandom, g1, g2);
    // Back-to-back DM read then IF read.
    drive(1, 0, 0, 1, 0, 32'h300, 0, 2'b10, $urandom, g1, g2);
    drive(1, 1, 32'h304, 0, 0, 0, 0, 0, $urandom, g1, g2);
    drive(1, 0, 0, 0, 0, 0, 0, 0, $urandom, g1, g2);
    // Load returning 0xABCD, then a store that must not disturb DmRdata.
    drive(1, 0, 0, 1, 0, 32'h400, 0, 2'b10, 32'h0000ABCD, g1, g2);
    drive(1, 0, 0, 1, 1, 32'h404, 32'h77, 2'b01, $urandom, g1, g2);
    drive(1, 0, 0, 0, 0, 0, 0, 0, $urandom, g1, g2);
    // Read grant followed by reset: the response is dropped.
    drive(1, 0, 0, 1, 0, 32'h500, 0, 2'b00, 32'hDEADBEEF, g1, g2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, $urandom, g1, g2);
    drive(1, 0, 0, 0, 0, 0, 0, 0, $urandom, g1, g2);

    ir = 0; dr = 0; ia = '0; da = '0; dw = 0; dwd = '0; ds = '0;
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      rst = ($urandom_range(0, 63) != 0);
      if (!ir && $urandom_range(0, 3) != 0) begin ir = 1; ia = $urandom; end
      if (!dr && $urandom_range(0, 2) != 0) begin
        dr = 1; dw = 1'($urandom); da = $urandom; dwd = $urandom;
        ds = 2'($urandom_range(0, 2));
      end
      drive(rst, ir, ia, dr, dw, da, dwd, ds, $urandom, g1, g2);
      if (g1) ir = 0;
      if (g2) dr = 0;
    end

    drive(1, 0, 0, 0, 0, 0, 0, 0, $urandom, g1, g2);
    drive(1, 0, 0, 0, 0, 0, 0, 0, $urandom, g1, g2);
    @(negedge Clk);
    #1;
    chk("resp_queue_drained", 32'(respq.size()), 0);
    chk("cycle_queue_drained", 32'(cycq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
